// File: rtl/pixel_scan_controller.sv
// Raster readout sequencer: walks the photodiode array, settles, triggers the ADC
// and streams each sample out over valid/ready. Build macro: PIXEL_TEST_PATTERN_EN.
module pixel_scan_controller #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int PIX_W         = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int ADC_TIMEOUT   = 255,
  localparam int RW           = $clog2(ROWS),
  localparam int CW           = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef PIXEL_TEST_PATTERN_EN
  input  logic             test_pattern,
`endif
  output logic             busy,
  output logic [RW-1:0]    row_addr,
  output logic [CW-1:0]    col_addr,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [PIX_W-1:0] adc_data,
  output logic [PIX_W-1:0] px_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             px_last,
  output logic             frame_done,
  output logic             adc_fault
);

  localparam int CNT_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ADC_TIMEOUT - 1);
  localparam logic [RW-1:0]    ROW_LAST     = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST     = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CONVERT, S_WAIT, S_OUTPUT, S_NEXT, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RW-1:0]    row_reg, row_next;
  logic [CW-1:0]    col_reg, col_next;
  logic [PIX_W-1:0] px_reg, px_next;
  logic             fault_reg, fault_next;
  logic             last_pix;
`ifdef PIXEL_TEST_PATTERN_EN
  logic             tp_reg, tp_next;
  logic [PIX_W-1:0] pattern;

  assign pattern = PIX_W'(int'(row_reg) * COLS + int'(col_reg));
`endif

  assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      px_reg    <= '0;
      fault_reg <= 1'b0;
`ifdef PIXEL_TEST_PATTERN_EN
      tp_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      px_reg    <= px_next;
      fault_reg <= fault_next;
`ifdef PIXEL_TEST_PATTERN_EN
      tp_reg    <= tp_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    px_next    = px_reg;
    fault_next = fault_reg;
`ifdef PIXEL_TEST_PATTERN_EN
    tp_next    = tp_reg;
`endif
    busy       = 1'b0;
    adc_start  = 1'b0;
    px_valid   = 1'b0;
    px_last    = 1'b0;
    frame_done = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_SETTLE;
          cnt_next   = '0;
          row_next   = '0;
          col_next   = '0;
          fault_next = 1'b0;
`ifdef PIXEL_TEST_PATTERN_EN
          tp_next    = test_pattern;
`endif
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = S_CONVERT;
`ifdef PIXEL_TEST_PATTERN_EN
          // Pattern frames keep the settle timing but bypass the ADC entirely.
          if (tp_reg) begin
            state_next = S_OUTPUT;
            px_next    = pattern;
          end
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_CONVERT: begin
        busy       = 1'b1;
        adc_start  = 1'b1;
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (adc_done) begin
          px_next    = adc_data;
          state_next = S_OUTPUT;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          // A dead converter must not stall the frame: emit zero and flag it.
          px_next    = '0;
          fault_next = 1'b1;
          state_next = S_OUTPUT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_OUTPUT: begin
        busy     = 1'b1;
        px_valid = 1'b1;
        px_last  = last_pix;
        if (px_ready) begin
          if (last_pix) begin
            state_next = S_DONE;
            row_next   = '0;
            col_next   = '0;
          end else begin
            state_next = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        busy       = 1'b1;
        cnt_next   = '0;
        state_next = S_SETTLE;
        if (col_reg == COL_LAST) begin
          col_next = '0;
          row_next = row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign row_addr  = row_reg;
  assign col_addr  = col_reg;
  assign px_data   = px_reg;
  assign adc_fault = fault_reg;

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Scoreboard bench for pixel_scan_controller: random frames against a pixel-level
// model of the raster, settle/ADC timing, stall, timeout and reset behaviour.
module tb_pixel_scan_controller;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int N     = ROWS * COLS;
  localparam int PIX_W = 8;
  localparam int S     = 8;
  localparam int T     = 30;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic [1:0]       row_addr;
  logic [1:0]       col_addr;
  logic             adc_start;
  logic             adc_done = 1'b0;
  logic [PIX_W-1:0] adc_data = '0;
  logic [PIX_W-1:0] px_data;
  logic             px_valid;
  logic             px_ready;
  logic             px_last;
  logic             frame_done;
  logic             adc_fault;
`ifdef PIXEL_TEST_PATTERN_EN
  logic             test_pattern;
`endif

  pixel_scan_controller #(
    .ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .SETTLE_CYCLES(S), .ADC_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef PIXEL_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .busy(busy), .row_addr(row_addr), .col_addr(col_addr), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_last(px_last), .frame_done(frame_done), .adc_fault(adc_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [PIX_W-1:0] img[N];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  start_cyc = -1;
  int  drop_idx = -1;
  int  adc_dly = 3;
  int  exp_frames = 0;
  bit  tp_frame = 1'b0;
  bit  spur_en = 1'b0;

  // Monitor-side model state
  int  out_idx = 0;
  int  exp_start_cyc = -1;
  int  exp_valid_cyc = -1;
  int  exp_done_cyc = -1;
  int  frames_done = 0;
  bit  exp_fault = 1'b0;
  bit  prev_valid = 1'b0;
  bit  prev_ready = 1'b0;
  bit  prev_last = 1'b0;
  logic [PIX_W-1:0] prev_data = '0;
  logic [3:0]       prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Analog front end: samples the image at the current address after adc_dly cycles
  int cd = -1;
  int pend = 0;
  always @(negedge clk) begin
    if (reset) begin
      cd = -1;
      adc_done = 1'b0;
    end else begin
      adc_done = 1'b0;
      adc_data = PIX_W'($urandom);
      if (cd == 0) begin
        adc_done = 1'b1;
        adc_data = img[pend];
        cd = -1;
      end else if (cd > 0) begin
        cd = cd - 1;
      end
      if (adc_start) begin
        pend = int'(row_addr) * COLS + int'(col_addr);
        if (pend != drop_idx) cd = adc_dly - 1;
        if (spur_en && $urandom_range(0, 1) == 1) begin
          adc_done = 1'b1;
          adc_data = ~img[pend];
        end
      end else if (cd < 0 && px_valid && spur_en && $urandom_range(0, 1) == 1) begin
        adc_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {busy, px_valid, adc_start, frame_done, adc_fault, row_addr, col_addr}, 32'd0);
      out_idx = 0;
      exp_start_cyc = -1;
      exp_valid_cyc = -1;
      exp_done_cyc = -1;
      exp_fault = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (start_cyc >= 0 && cyc == start_cyc + 1) begin
        check("busy_after_start", busy, 1);
        check("fault_cleared", adc_fault, 0);
        check("start_addr", {row_addr, col_addr}, 0);
        exp_fault = 1'b0;
        out_idx = 0;
        exp_start_cyc = tp_frame ? -1 : cyc + S;
        exp_valid_cyc = tp_frame ? cyc + S : -1;
      end
      if (adc_start) begin
        check("adc_start_cycle", cyc, exp_start_cyc);
        exp_start_cyc = -1;
        exp_valid_cyc = cyc + ((out_idx == drop_idx) ? T + 1 : adc_dly + 1);
      end
      if (px_valid && !prev_valid) begin
        check("valid_cycle", cyc, exp_valid_cyc);
        check("valid_addr", {row_addr, col_addr}, {2'(out_idx / COLS), 2'(out_idx % COLS)});
        exp_valid_cyc = -1;
        if (!tp_frame && out_idx == drop_idx) exp_fault = 1'b1;
        check("fault_state", adc_fault, exp_fault);
      end
      if (prev_valid && !prev_ready)
        check("stall_hold", {px_valid, px_last, px_data, row_addr, col_addr},
              {1'b1, prev_last, prev_data, prev_addr});
      if (px_valid && px_ready) begin
        check("px_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          $display("px %0d (%0d,%0d) data=%02h last=%0b fault=%0b", out_idx, row_addr, col_addr,
                   px_data, px_last, adc_fault);
          check("px_data", px_data, e.data);
          check("px_last", px_last, e.last);
          check("fault_sticky", adc_fault, exp_fault);
          out_idx++;
          if (e.last) begin
            exp_done_cyc = cyc + 1;
          end else if (tp_frame) begin
            exp_valid_cyc = cyc + 2 + S;
          end else begin
            exp_start_cyc = cyc + 2 + S;
          end
        end
      end
      if (frame_done) begin
        check("done_cycle", cyc, exp_done_cyc);
        check("done_state", {busy, row_addr, col_addr}, 0);
        check("done_fault", adc_fault, exp_fault);
        check("done_queue_empty", exp_q.size(), 0);
        frames_done++;
        exp_done_cyc = -1;
      end
      prev_valid = px_valid;
      prev_ready = px_ready;
      prev_last  = px_last;
      prev_data  = px_data;
      prev_addr  = {row_addr, col_addr};
    end
  end

  task automatic load_frame(input int drop, input bit tp, input bit spur, input int dly);
    drop_idx = drop;
    tp_frame = tp;
    spur_en  = spur;
    adc_dly  = dly;
    for (int k = 0; k < N; k++) begin
      exp_t e;
      img[k] = PIX_W'($urandom);
      e.last = (k == N - 1);
      if (tp) e.data = PIX_W'(k);
      else if (k == drop) e.data = '0;
      else e.data = img[k];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
`ifdef PIXEL_TEST_PATTERN_EN
    test_pattern = tp;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int drop, input int stall_px, input bit noise, input bit rnd_rdy,
                           input bit tp, input bit spur, input int dly);
    int n;
    bit done;
    int stall_left;
    load_frame(drop, tp, spur, dly);
    n = 0;
    done = 1'b0;
    stall_left = 20;
    while (!done && n < 3000) begin
      if (frame_done) done = 1'b1;
      start = noise && (frame_done || (busy && $urandom_range(0, 7) == 0));
      if (px_valid && out_idx == stall_px && stall_left > 0) begin
        px_ready = 1'b0;
        stall_left--;
      end else begin
        px_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("frame_watchdog", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    px_ready = 1'b0;
    exp_frames++;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_frame", busy, 0);
    if (!done) exp_q.delete();
  endtask

  task automatic reset_mid_frame();
    int n;
    load_frame(2, 1'b0, 1'b0, 2);
    px_ready = 1'b1;
    n = 0;
    while (!(adc_start && out_idx == 2) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_wait_adc", adc_start && out_idx == 2, 1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    start_cyc = -1;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_start_ignored", busy, 0);
    px_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    px_ready = 1'b0;
`ifdef PIXEL_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_frame(-1, 4, 1'b0, 1'b1, 1'b0, 1'b1, int'($urandom_range(1, 5)));
    run_frame(2, -1, 1'b0, 1'b1, 1'b0, 1'b1, int'($urandom_range(1, 5)));
    run_frame(-1, -1, 1'b1, 1'b1, 1'b0, 1'b1, int'($urandom_range(1, 5)));
    reset_mid_frame();
    run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++)
      run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1,
                int'($urandom_range(0, N - 1)), 1'b1, 1'b1, 1'b0, 1'b1,
                int'($urandom_range(1, 5)));
`ifdef PIXEL_TEST_PATTERN_EN
    run_frame(-1, -1, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
`endif
    check("frame_count", frames_done, exp_frames);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
